// File: rtl/dlbf_pkg.sv
// Shared constants for the DLBF slave receive path.
// State encodings are exported to the control side as-is.
package dlbf_pkg;

    localparam int TDATA_WIDTH = 64;
    localparam int RAM_DEPTH   = 1536;
    localparam int ADDR_WIDTH  = 16;
    localparam int NITER_WIDTH = 12;
    localparam int CNT_WIDTH   = 16;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_ARM       = 4'd1;
    localparam logic [3:0] ST_CAPTURE   = 4'd2;
    localparam logic [3:0] ST_ITER_DONE = 4'd3;
    localparam logic [3:0] ST_DONE      = 4'd4;

endpackage

// File: rtl/dlbf_slave_seq.sv
// Capture sequencer: gates S_AXIS into frames of RAM_DEPTH beats,
// writes the slave RAM and tracks iterations and TLAST framing.
module dlbf_slave_seq
    import dlbf_pkg::*;
#(
    parameter int TDATA_WIDTH = dlbf_pkg::TDATA_WIDTH,
    parameter int TKEEP_WIDTH = TDATA_WIDTH / 8,
    parameter int RAM_DEPTH   = dlbf_pkg::RAM_DEPTH,
    parameter int ADDR_WIDTH  = dlbf_pkg::ADDR_WIDTH
) (
    input  logic                   s_axis_clk,
    input  logic                   s_axis_aresetn,
    input  logic                   start,
    input  logic                   abort,
    input  logic [NITER_WIDTH-1:0] niter,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic [TKEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                   s_axis_tlast,
    output logic [TKEEP_WIDTH-1:0] ram_we,
    output logic [ADDR_WIDTH-1:0]  ram_addr,
    output logic [TDATA_WIDTH-1:0] ram_din,
    output logic                   busy,
    output logic                   rxdone,
    output logic                   err_tlast,
    output logic [3:0]             current_state,
    output logic [CNT_WIDTH-1:0]   rxram_counter,
    output logic [NITER_WIDTH-1:0] iter_count
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    logic [3:0]             state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [NITER_WIDTH-1:0] iter_q, iter_d;
    logic [NITER_WIDTH-1:0] niter_q, niter_d;
    logic                   err_q, err_d;
    logic                   rxdone_q, rxdone_d;
    logic [TKEEP_WIDTH-1:0] we_q, we_d;
    logic [ADDR_WIDTH-1:0]  waddr_q, waddr_d;
    logic [TDATA_WIDTH-1:0] din_q, din_d;

    logic                   tready;
    logic                   acc;
    logic                   at_last;
    logic                   start_ok;
    logic [NITER_WIDTH-1:0] iter_nx;

    assign tready   = (state_q == ST_CAPTURE);
    assign acc      = s_axis_tvalid & tready;
    assign at_last  = (addr_q == LAST_ADDR);
    assign start_ok = start & ~abort
                    & ((state_q == ST_IDLE) | (state_q == ST_DONE));
    assign iter_nx  = iter_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        iter_d   = iter_q;
        niter_d  = niter_q;
        err_d    = err_q;
        rxdone_d = rxdone_q;
        we_d     = '0;
        waddr_d  = waddr_q;
        din_d    = din_q;

        // Beat bookkeeping runs even in an abort cycle so the beat is kept.
        if (acc) begin
            we_d    = s_axis_tkeep;
            waddr_d = addr_q;
            din_d   = s_axis_tdata;
            addr_d  = addr_q + 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            if (s_axis_tlast != at_last) err_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    state_d  = ST_ARM;
                    niter_d  = niter;
                    addr_d   = '0;
                    cnt_d    = '0;
                    iter_d   = '0;
                    err_d    = 1'b0;
                    rxdone_d = 1'b0;
                end
            end
            ST_ARM: begin
                state_d = (niter_q == '0) ? ST_DONE : ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (acc && (s_axis_tlast || at_last)) state_d = ST_ITER_DONE;
            end
            ST_ITER_DONE: begin
                if (iter_q != '1) iter_d = iter_nx;
                addr_d  = '0;
                state_d = (iter_nx == niter_q) ? ST_DONE : ST_CAPTURE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort) state_d = ST_IDLE;
        if (state_d == ST_DONE) rxdone_d = 1'b1;
    end

    always_ff @(posedge s_axis_clk) begin
        if (!s_axis_aresetn) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            iter_q   <= '0;
            niter_q  <= '0;
            err_q    <= 1'b0;
            rxdone_q <= 1'b0;
            we_q     <= '0;
            waddr_q  <= '0;
            din_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            iter_q   <= iter_d;
            niter_q  <= niter_d;
            err_q    <= err_d;
            rxdone_q <= rxdone_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            din_q    <= din_d;
        end
    end

    assign s_axis_tready = tready;
    assign ram_we        = we_q;
    assign ram_addr      = waddr_q;
    assign ram_din       = din_q;
    assign busy          = (state_q == ST_ARM) | (state_q == ST_CAPTURE)
                         | (state_q == ST_ITER_DONE);
    assign rxdone        = rxdone_q;
    assign err_tlast     = err_q;
    assign current_state = state_q;
    assign rxram_counter = cnt_q;
    assign iter_count    = iter_q;

endmodule

// File: doc/dlbf_slave_seq.md
# dlbf_slave_seq

Capture sequencer for the DLBF slave receive path, in the AXIS clock domain. It accepts a start command and iteration count from the control side and gates the S_AXIS stream. It drives the slave RAM write port with frame-relative addresses, counts frames of RAM_DEPTH beats and checks TLAST framing. It reports state, beat count and done status back to the control side through the existing CDC.

## Interface
- TDATA_WIDTH, 64: stream and RAM data width.
- TKEEP_WIDTH, TDATA_WIDTH/8: byte-enable width.
- RAM_DEPTH, 1536: beats per frame; RAM addresses 0..RAM_DEPTH-1.
- ADDR_WIDTH, 16: RAM address and counter width.
- Clocking and reset (already decided): one clock; reset is synchronous and active-low.
- s_axis_clk  in  1  sole clock.
- s_axis_aresetn  in  1  synchronous active-low reset.
- start  in  1  single-cycle start pulse; ignored unless state is IDLE or DONE.
- abort  in  1  level; forces IDLE.
- niter  in  12  frames to capture; sampled on an accepted start.
- s_axis_tvalid  in  1  AXIS valid.
- s_axis_tready  out  1  AXIS ready.
- s_axis_tdata  in  TDATA_WIDTH  AXIS data.
- s_axis_tkeep  in  TKEEP_WIDTH  AXIS byte keep.
- s_axis_tlast  in  1  AXIS last.
- ram_we  out  TKEEP_WIDTH  RAM byte write enables.
- ram_addr  out  ADDR_WIDTH  RAM write address.
- ram_din  out  TDATA_WIDTH  RAM write data.
- busy  out  1  high in ARM, CAPTURE and ITER_DONE.
- rxdone  out  1  level; all niter frames captured.
- err_tlast  out  1  sticky framing error.
- current_state  out  4  state encoding.
- rxram_counter  out  16  total beats accepted since the last start (saturating).
- iter_count  out  12  frames completed.

## Operation
- States and encodings: IDLE=0, ARM=1, CAPTURE=2, ITER_DONE=3, DONE=4.
- IDLE/DONE to ARM: on start.
  - ARM latches niter.
  - ARM clears the beat address, rxram_counter, iter_count, err_tlast and rxdone.
- ARM to CAPTURE: on the next cycle. If the latched niter is 0, ARM goes to DONE instead.
- CAPTURE:
  - s_axis_tready = 1 (combinational decode of state).
  - Each beat with tvalid&tready writes RAM at the current beat address, then increments the address and rxram_counter.
  - The frame ends on whichever comes first: the beat at address RAM_DEPTH-1, or an accepted tlast. The state then goes to ITER_DONE.
- TLAST check:
  - tlast on a beat other than RAM_DEPTH-1 (early): set err_tlast and end the frame early.
  - tlast absent on beat RAM_DEPTH-1 (missing): set err_tlast and end the frame anyway.
  - err_tlast stays set until the next start or reset.
- ITER_DONE (one cycle, tready=0):
  - iter_count increments.
  - The beat address resets to 0.
  - If iter_count+1 equals niter, go to DONE; otherwise go to CAPTURE.
- DONE: rxdone=1, tready=0. rxdone is held until the next start or reset.
- abort:
  - In any state, the next state is IDLE.
  - tready drops in the next cycle.
  - A beat accepted in the abort cycle is still written.
  - rxdone is not set. Counters hold their values for readback.
- start while busy: ignored. start and abort in the same cycle: abort wins.
- rxram_counter saturates at 0xFFFF. iter_count cannot exceed 4095.
- Each frame overwrites RAM addresses from 0; after DONE the RAM holds the last frame.

## Timing
- Reset values: tready=0, ram_we=0, ram_addr=0, ram_din=0, busy=0, rxdone=0, err_tlast=0, current_state=0, rxram_counter=0, iter_count=0.
- Write latency: ram_we, ram_addr and ram_din are registered. A beat accepted in cycle N is presented to the RAM in cycle N+1. ram_we=tkeep for an accepted beat, otherwise 0.
- start to first tready: 2 cycles (ARM, then CAPTURE).
- Inter-frame bubble: exactly 1 cycle of tready=0 (ITER_DONE).
- Last accepted beat to rxdone=1: 2 cycles.
- tready never depends combinationally on tvalid.

## Structure
- Package dlbf_pkg holds:
  - the state encodings (4-bit localparams);
  - the default widths (TDATA_WIDTH, RAM_DEPTH, ADDR_WIDTH);
  - the niter width (12).
- No sub-module: the beat counter, iteration counter and FSM are inline.
- start is supplied as a pulse by the CDC side.

## Test plan
- Single frame: niter=1, 1536 contiguous beats with tlast on beat 1535.
  - ram_addr runs 0..1535 with ram_we=0xFF.
  - rxram_counter=1536, iter_count=1, rxdone rises 2 cycles after the last beat, err_tlast=0.
- Multi-frame with backpressure: niter=3, tvalid toggling randomly.
  - rxram_counter=4608, iter_count=3.
  - Exactly one tready-low cycle between frames; each frame's ram_addr restarts at 0.
- Framing errors, niter=2:
  - Frame 0 has early tlast on beat 99: frame ends at beat 99, err_tlast=1, frame 1 starts at address 0.
  - Frame 1 has tlast missing on beat 1535: frame still ends there, rxdone=1, rxram_counter=1636.
- Zero iterations: niter=0 with start. ARM then DONE, rxdone=1 after 2 cycles, no beat accepted.
- Abort mid-frame: abort at beat 500.
  - IDLE the next cycle, tready=0, rxdone=0, rxram_counter holds 501 (including the beat accepted in the abort cycle).
  - A new start clears all counters.
- Reset mid-capture: s_axis_aresetn=0 for 1 cycle at beat 700. All outputs return to reset values on the next edge; a start during reset is ignored.
